// File: rtl/gerador_controle.sv
// gerador_controle: input front-end for the car game.
// Synchronizes and debounces the two raw push-buttons, then turns the
// debounced levels into one-cycle step strobes on `control`
// (2'b10 = right, 2'b01 = left, 2'b00 = idle; 2'b11 is never driven).
// Optional feature: define GERADOR_AUTO_REPEAT_EN to enable auto-repeat
// while a button is held. Without it each accepted press yields one strobe.
module gerador_controle #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [1:0] control,
  output logic       held_left,
  output logic       held_right
);

  // Index 0 is the left button, index 1 the right button throughout.
  localparam int unsigned NBTN = 2;
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] CODE_IDLE  = 2'b00;
  localparam logic [1:0] CODE_LEFT  = 2'b01;
  localparam logic [1:0] CODE_RIGHT = 2'b10;

`ifdef GERADOR_AUTO_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  // Counter is loaded on the strobe edge and expires when it reads zero,
  // so a load of N-1 places the next strobe exactly N edges later.
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_DELAY  = 2'd2,
    ST_REPEAT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_HELD  = 2'd2
  } state_t;
`endif

  // Reject zero-valued timing parameters at elaboration.
  if (DEBOUNCE_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_param
    $error("gerador_controle: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic [NBTN-1:0] r_sync1;
  logic [NBTN-1:0] r_sync2;
  logic [NBTN-1:0] r_stable;
  logic [DB_W-1:0] r_db_cnt [NBTN];

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_dir;          // latched direction: 1 = right, 0 = left
  logic       w_dir_nxt;
  logic [1:0] r_control;
  logic [1:0] w_control_nxt;

`ifdef GERADOR_AUTO_REPEAT_EN
  logic [REP_W-1:0] r_rep;
  logic [REP_W-1:0] w_rep_nxt;
  logic             w_rep_expired;
  logic [1:0]       w_code_cur;
`endif

  logic       w_req_right;
  logic       w_req_left;
  logic       w_req_any;
  logic       w_reversed;
  logic [1:0] w_code_req;

  // Two-flop synchronizer for both raw buttons.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {btn_right, btn_left};
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: a new level is accepted after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stable <= '0;
      for (int i = 0; i < NBTN; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_stable[i] <= ~r_stable[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Direction request from debounced levels; both or neither held means no request.
  always_comb begin
    w_req_right = r_stable[1] & ~r_stable[0];
    w_req_left  = r_stable[0] & ~r_stable[1];
    w_req_any   = w_req_right | w_req_left;
    w_reversed  = w_req_any & (w_req_right != r_dir);
    w_code_req  = w_req_right ? CODE_RIGHT : CODE_LEFT;
  end

`ifdef GERADOR_AUTO_REPEAT_EN
  // Repeat timer status and the code of the direction currently being repeated.
  always_comb begin
    w_rep_expired = (r_rep == '0);
    w_code_cur    = r_dir ? CODE_RIGHT : CODE_LEFT;
  end
`endif

  // FSM state, latched direction, repeat timer and registered strobe output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_dir     <= 1'b0;
      r_control <= CODE_IDLE;
`ifdef GERADOR_AUTO_REPEAT_EN
      r_rep     <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_dir     <= w_dir_nxt;
      r_control <= w_control_nxt;
`ifdef GERADOR_AUTO_REPEAT_EN
      r_rep     <= w_rep_nxt;
`endif
    end
  end

  // Next-state and strobe decode; the strobe is registered with the transition that emits it.
  always_comb begin
    w_state_nxt   = r_state;
    w_dir_nxt     = r_dir;
    w_control_nxt = CODE_IDLE;
`ifdef GERADOR_AUTO_REPEAT_EN
    w_rep_nxt     = r_rep;
`endif

    case (r_state)
      ST_IDLE: begin
        if (w_req_any) begin
          w_state_nxt   = ST_FIRST;
          w_dir_nxt     = w_req_right;
          w_control_nxt = w_code_req;
`ifdef GERADOR_AUTO_REPEAT_EN
          w_rep_nxt     = REP_FIRST;
`endif
        end
      end

`ifdef GERADOR_AUTO_REPEAT_EN
      ST_FIRST, ST_DELAY, ST_REPEAT: begin
        if (!w_req_any) begin
          // Released or both held: stop without a further strobe.
          w_state_nxt = ST_IDLE;
        end else if (w_reversed) begin
          // Opposite direction is a fresh press.
          w_state_nxt   = ST_FIRST;
          w_dir_nxt     = w_req_right;
          w_control_nxt = w_code_req;
          w_rep_nxt     = REP_FIRST;
        end else if (w_rep_expired) begin
          w_state_nxt   = ST_REPEAT;
          w_control_nxt = w_code_cur;
          w_rep_nxt     = REP_NEXT;
        end else begin
          w_state_nxt = (r_state == ST_REPEAT) ? ST_REPEAT : ST_DELAY;
          w_rep_nxt   = r_rep - REP_W'(1);
        end
      end
`else
      ST_FIRST, ST_HELD: begin
        if (!w_req_any) begin
          w_state_nxt = ST_IDLE;
        end else if (w_reversed) begin
          w_state_nxt   = ST_FIRST;
          w_dir_nxt     = w_req_right;
          w_control_nxt = w_code_req;
        end else begin
          w_state_nxt = ST_HELD;
        end
      end
`endif

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign control    = r_control;
  assign held_left  = r_stable[0];
  assign held_right = r_stable[1];

endmodule

// File: tb/tb_gerador_controle.sv
// Scoreboard bench for gerador_controle.
// A cycle-level reference model derives expected outputs from button-press
// timing (age since press) and pushes them into a queue; a negedge monitor
// pops and compares against the DUT. Follows GERADOR_AUTO_REPEAT_EN.
module tb_gerador_controle;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic [1:0] control;
  logic       held_left;
  logic       held_right;

  int total = 0;
  int bad   = 0;
  int got_strobes = 0;
  int exp_strobes = 0;

  gerador_controle #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .control   (control),
    .held_left (held_left),
    .held_right(held_right)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ctrl;
    logic       hl;
    logic       hr;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state.
  logic [1:0] m_s1, m_s2, m_stable;
  int         m_run [2];
  bit         m_active;
  bit         m_dir_right;
  int         m_age;
  logic [1:0] m_out;
  bit         m_rq_r, m_rq_l;

  // Reference model: strobe when a press starts, then at ages RD, RD+RP, ...
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0;
      m_run[0] = 0; m_run[1] = 0;
      m_active = 0; m_dir_right = 0; m_age = 0;
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      m_rq_r = m_stable[1] && !m_stable[0];
      m_rq_l = m_stable[0] && !m_stable[1];
      m_out  = 2'b00;
      if (!(m_rq_r || m_rq_l)) begin
        m_active = 0;
      end else if (!m_active || (m_rq_r != m_dir_right)) begin
        m_active    = 1;
        m_dir_right = m_rq_r;
        m_age       = 0;
        m_out       = m_rq_r ? 2'b10 : 2'b01;
      end else begin
        m_age++;
`ifdef GERADOR_AUTO_REPEAT_EN
        if (m_age >= int'(RD) && ((m_age - int'(RD)) % int'(RP)) == 0)
          m_out = m_dir_right ? 2'b10 : 2'b01;
`endif
      end
      for (int i = 0; i < 2; i++) begin
        if (m_s2[i] == m_stable[i]) m_run[i] = 0;
        else if (m_run[i] == int'(DB) - 1) begin
          m_stable[i] = ~m_stable[i];
          m_run[i]    = 0;
        end else m_run[i]++;
      end
      m_s2 = m_s1;
      m_s1 = {btn_right, btn_left};
      exp_q.push_back({m_out, m_stable[0], m_stable[1]});
    end
  end

  // Monitor: compare DUT outputs against the model on the falling edge.
  exp_t e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.ctrl != 2'b00) exp_strobes++;
      if (control != 2'b00) got_strobes++;
      total++;
      if ({control, held_left, held_right} !== e) begin
        bad++;
        $display("FAIL outputs t=%0t got ctrl=%b hl=%b hr=%b exp ctrl=%b hl=%b hr=%b",
                 $time, control, held_left, held_right, e.ctrl, e.hl, e.hr);
      end
      total++;
      if (control === 2'b11) begin
        bad++;
        $display("FAIL ctrl_11 t=%0t got ctrl=%b exp not 11", $time, control);
      end
    end
  end

  // Hold a button pattern for n sampling edges.
  task automatic drive(input logic l, input logic r, input int n);
    @(posedge clk);
    #2;
    btn_left  = l;
    btn_right = r;
    repeat (n - 1) @(posedge clk);
  endtask

  // Reset pulse of a few cycles, buttons untouched.
  task automatic pulse_reset(input int n);
    @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    drive(0, 0, 5);
    drive(1, 0, 3);                   // glitch on left
    drive(0, 0, 20);
    drive(0, 1, 30);                  // hold right
    drive(0, 0, 20);
    drive(0, 1, 12);                  // reset mid-run, right held
    pulse_reset(3);
    repeat (25) @(posedge clk);
    drive(0, 0, 20);
    drive(1, 0, int'(DB) + 3 + int'(RD) + 1);  // left until first repeat
    drive(0, 1, 30);                  // reversal to right
    drive(0, 0, 20);
    drive(1, 1, 30);                  // both held
    drive(0, 1, 30);                  // release left
    drive(0, 0, 20);
    drive(0, 1, 40);                  // long hold, then re-press
    drive(0, 0, 15);
    drive(0, 1, 20);
    drive(0, 0, 15);
    drive(1, 0, 2);                   // glitches of assorted widths
    drive(0, 0, 6);
    drive(0, 1, 4);
    drive(0, 0, 10);

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 19) == 0) pulse_reset($urandom_range(1, 3));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 25));
    end

    drive(0, 0, 30);
    @(negedge clk);
    total++;
    if (got_strobes != exp_strobes) begin
      bad++;
      $display("FAIL strobe_count got=%0d exp=%0d", got_strobes, exp_strobes);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
